// File: rtl/seq_decimalizer.sv
// ---------------------------------------------------------------------------
// seq_decimalizer
//   Sequential binary-to-BCD converter for a group of CHANNELS unsigned
//   values. One input bit is consumed per clock with the shift-add-3
//   (double-dabble) algorithm, channel 0 first. A value that does not fit
//   in DIGITS decimal digits saturates to all nines and raises its
//   overflow flag. The published results change only on the edge that
//   enters DONE, so they stay stable through the next conversion.
//
// Ports
//   clk          : clock, rising edge active
//   rst_n        : asynchronous active-low reset
//   in_valid     : request to convert in_values
//   in_ready     : high in IDLE and DONE (request accepted on in_valid)
//   in_values    : CHANNELS x W_IN packed inputs, channel c at [c*W_IN +: W_IN]
//   out_valid    : one-cycle pulse in the DONE cycle
//   out_digits   : packed BCD, digit d of channel c at [(c*DIGITS+d)*4 +: 4]
//   out_blank    : leading-zero mask, same order as out_digits
//   out_overflow : per-channel saturation flag
// ---------------------------------------------------------------------------
module seq_decimalizer #(
    parameter int W_IN     = 8,
    parameter int DIGITS   = 3,
    parameter int CHANNELS = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*W_IN-1:0]       in_values,
    output logic                           out_valid,
    output logic [CHANNELS*DIGITS*4-1:0]   out_digits,
    output logic [CHANNELS*DIGITS-1:0]     out_blank,
    output logic [CHANNELS-1:0]            out_overflow
);

    localparam int BCD_W  = DIGITS * 4;
    localparam int WORK_W = BCD_W + W_IN;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BIT_W  = (W_IN > 1) ? $clog2(W_IN) : 1;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W_IN - 1);
    localparam logic [31:0]      MAX_VAL  = 32'(10 ** DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [W_IN-1:0]   cap [CHANNELS];
    logic [BCD_W-1:0]  stage_digits [CHANNELS];
    logic [CHANNELS-1:0] stage_ovf;
    logic [CH_W-1:0]   ch_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WORK_W-1:0] work;

    logic [WORK_W-1:0] src;
    logic [WORK_W-1:0] step_res;
    logic [31:0]       cap_ext;
    logic              ch_ovf;
    logic [BCD_W-1:0]  ch_digits;
    logic              accept;
    logic              bit_last;
    logic              ch_last;

    // One double-dabble iteration: add 3 to every BCD digit >= 5, then
    // shift the whole register left so the binary MSB enters the BCD field.
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] r;
        r = w;
        for (int d = 0; d < DIGITS; d++) begin
            if (r[W_IN + d*4 +: 4] >= 4'd5)
                r[W_IN + d*4 +: 4] = r[W_IN + d*4 +: 4] + 4'd3;
        end
        return {r[WORK_W-2:0], 1'b0};
    endfunction

    function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] bcd,
                                                   input logic ovf);
        logic [BCD_W-1:0] r;
        r = bcd;
        if (ovf) begin
            for (int d = 0; d < DIGITS; d++)
                r[d*4 +: 4] = 4'd9;
        end
        return r;
    endfunction

    // A digit is blank when it and every more-significant digit are zero;
    // the units digit always shows.
    function automatic logic [DIGITS-1:0] blank_of(input logic [BCD_W-1:0] bcd);
        logic [DIGITS-1:0] b;
        logic              z;
        b = '0;
        z = 1'b1;
        for (int d = DIGITS - 1; d > 0; d--) begin
            z    = z & (bcd[d*4 +: 4] == 4'd0);
            b[d] = z;
        end
        return b;
    endfunction

    assign accept   = in_valid && in_ready;
    assign bit_last = (bit_cnt == BIT_LAST);
    assign ch_last  = (ch_cnt == CH_LAST);

    // The first bit of every channel starts from a cleared BCD field with
    // the captured value loaded below it.
    always_comb begin
        src = work;
        if (bit_cnt == '0) begin
            src             = '0;
            src[W_IN-1:0]   = cap[ch_cnt];
        end
        step_res = dabble_step(src);
        cap_ext             = '0;
        cap_ext[W_IN-1:0]   = cap[ch_cnt];
        ch_ovf    = (cap_ext > MAX_VAL);
        ch_digits = saturate(step_res[WORK_W-1 -: BCD_W], ch_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = CONVERT;
            end
            CONVERT: begin
                if (bit_last && ch_last)
                    state_next = DONE;
            end
            DONE: begin
                in_ready   = 1'b1;
                out_valid  = 1'b1;
                state_next = in_valid ? CONVERT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cap[c]          <= '0;
                stage_digits[c] <= '0;
            end
            stage_ovf    <= '0;
            ch_cnt       <= '0;
            bit_cnt      <= '0;
            work         <= '0;
            out_digits   <= '0;
            out_blank    <= '0;
            out_overflow <= '0;
        end else if (accept) begin
            for (int c = 0; c < CHANNELS; c++)
                cap[c] <= in_values[c*W_IN +: W_IN];
            ch_cnt  <= '0;
            bit_cnt <= '0;
            work    <= '0;
        end else if (state == CONVERT) begin
            work <= step_res;
            if (bit_last) begin
                bit_cnt              <= '0;
                stage_digits[ch_cnt] <= ch_digits;
                stage_ovf[ch_cnt]    <= ch_ovf;
                if (!ch_last) begin
                    ch_cnt <= ch_cnt + CH_W'(1);
                end else begin
                    // Publish every channel at once; the last channel comes
                    // straight from this cycle's result.
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (c == CHANNELS - 1) begin
                            out_digits[c*BCD_W +: BCD_W]   <= ch_digits;
                            out_blank[c*DIGITS +: DIGITS]  <= blank_of(ch_digits);
                            out_overflow[c]                <= ch_ovf;
                        end else begin
                            out_digits[c*BCD_W +: BCD_W]   <= stage_digits[c];
                            out_blank[c*DIGITS +: DIGITS]  <= blank_of(stage_digits[c]);
                            out_overflow[c]                <= stage_ovf[c];
                        end
                    end
                end
            end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_decimalizer.sv
// ---------------------------------------------------------------------------
// tb_seq_decimalizer
//   Drives three instances of seq_decimalizer (default, DIGITS=2 and a wide
//   single-channel build) and compares their results with a decimal model
//   built from integer division.
// ---------------------------------------------------------------------------
module tb_seq_decimalizer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (W_IN=8, DIGITS=3, CHANNELS=6)
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [47:0] a_vals = '0;
    logic        a_ov;
    logic [71:0] a_dig;
    logic [17:0] a_blank;
    logic [5:0]  a_ovf;

    // Instance B: W_IN=8, DIGITS=2, CHANNELS=2
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [15:0] b_vals = '0;
    logic        b_ov;
    logic [15:0] b_dig;
    logic [3:0]  b_blank;
    logic [1:0]  b_ovf;

    // Instance C: W_IN=16, DIGITS=4, CHANNELS=1
    logic        c_valid = 1'b0;
    logic        c_ready;
    logic [15:0] c_vals = '0;
    logic        c_ov;
    logic [15:0] c_dig;
    logic [3:0]  c_blank;
    logic [0:0]  c_ovf;

    seq_decimalizer dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_values(a_vals), .out_valid(a_ov), .out_digits(a_dig),
        .out_blank(a_blank), .out_overflow(a_ovf)
    );

    seq_decimalizer #(.W_IN(8), .DIGITS(2), .CHANNELS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_values(b_vals), .out_valid(b_ov), .out_digits(b_dig),
        .out_blank(b_blank), .out_overflow(b_ovf)
    );

    seq_decimalizer #(.W_IN(16), .DIGITS(4), .CHANNELS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready),
        .in_values(c_vals), .out_valid(c_ov), .out_digits(c_dig),
        .out_blank(c_blank), .out_overflow(c_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decimal model: saturate to 10^nd-1, split with division, and blank
    // digit d>0 whenever the shown value is below 10^d.
    function automatic void model(input int v, input int nd,
                                  output logic [15:0] dig, output logic [3:0] blk,
                                  output logic ovf);
        int lim, e, p;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        ovf = (v > lim - 1);
        e   = ovf ? lim - 1 : v;
        dig = '0;
        blk = '0;
        p   = 1;
        for (int d = 0; d < nd; d++) begin
            dig[d*4 +: 4] = 4'((e / p) % 10);
            blk[d]        = (d > 0) && (e < p);
            p = p * 10;
        end
    endfunction

    task automatic verify_a(input string tag, input logic [47:0] vals);
        logic [15:0] dig;
        logic [3:0]  blk;
        logic        ovf;
        for (int c = 0; c < 6; c++) begin
            model(int'(vals[c*8 +: 8]), 3, dig, blk, ovf);
            check_eq($sformatf("%s_c%0d_dig", tag, c), a_dig[c*12 +: 12], dig[11:0]);
            check_eq($sformatf("%s_c%0d_blank", tag, c), a_blank[c*3 +: 3], blk[2:0]);
            check_eq($sformatf("%s_c%0d_ovf", tag, c), a_ovf[c], ovf);
        end
    endtask

    // Counts cycles from the accepting edge (the request cycle is cycle 0).
    task automatic wait_a(inout int lat);
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (a_ov) break;
        end
        check_eq("a_out_valid_seen", a_ov, 1'b1);
    endtask

    task automatic a_start(input logic [47:0] vals);
        @(negedge clk);
        check_eq("a_ready_before_req", a_ready, 1'b1);
        a_vals  = vals;
        a_valid = 1'b1;
        @(posedge clk);
        #1 a_valid = 1'b0;
    endtask

    task automatic a_run(input string tag, input logic [47:0] vals);
        int lat;
        a_start(vals);
        lat = 0;
        wait_a(lat);
        check_eq({tag, "_latency"}, 64'(lat), 64'd49);
        verify_a(tag, vals);
    endtask

    task automatic b_run(input string tag, input logic [15:0] vals);
        int lat;
        logic [15:0] dig;
        logic [3:0]  blk;
        logic        ovf;
        @(negedge clk);
        b_vals  = vals;
        b_valid = 1'b1;
        @(posedge clk);
        #1 b_valid = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (b_ov) break;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd17);
        for (int c = 0; c < 2; c++) begin
            model(int'(vals[c*8 +: 8]), 2, dig, blk, ovf);
            check_eq($sformatf("%s_c%0d_dig", tag, c), b_dig[c*8 +: 8], dig[7:0]);
            check_eq($sformatf("%s_c%0d_blank", tag, c), b_blank[c*2 +: 2], blk[1:0]);
            check_eq($sformatf("%s_c%0d_ovf", tag, c), b_ovf[c], ovf);
        end
    endtask

    task automatic c_run(input string tag, input logic [15:0] vals);
        int lat;
        logic [15:0] dig;
        logic [3:0]  blk;
        logic        ovf;
        @(negedge clk);
        c_vals  = vals;
        c_valid = 1'b1;
        @(posedge clk);
        #1 c_valid = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (c_ov) break;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd17);
        model(int'(vals), 4, dig, blk, ovf);
        check_eq({tag, "_dig"}, c_dig, dig);
        check_eq({tag, "_blank"}, c_blank, blk);
        check_eq({tag, "_ovf"}, c_ovf, ovf);
    endtask

    initial begin
        logic [47:0] v1, v2, prev_dig;
        int lat, pulses;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_a_valid", a_ov, 1'b0);
        check_eq("rst_a_dig", a_dig, 72'd0);
        check_eq("rst_a_blank", a_blank, 18'd0);
        check_eq("rst_a_ovf", a_ovf, 6'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_a_ready_after", a_ready, 1'b1);
        check_eq("rst_c_ready_after", c_ready, 1'b1);

        // Directed defaults vector {0,7,42,99,255,100}
        a_run("dir", {8'd100, 8'd255, 8'd99, 8'd42, 8'd7, 8'd0});
        check_eq("dir_digits_const", a_dig,
                 {12'h100, 12'h255, 12'h099, 12'h042, 12'h007, 12'h000});
        check_eq("dir_blank_const", a_blank,
                 {3'b000, 3'b000, 3'b100, 3'b100, 3'b110, 3'b110});
        @(negedge clk);
        check_eq("dir_pulse_width", a_ov, 1'b0);

        // Randomised conversions
        for (int i = 0; i < 4; i++)
            a_run($sformatf("rnd%0d", i), {$urandom, $urandom});

        // Inputs and in_valid disturbed mid-conversion; outputs must hold
        v1       = {$urandom, $urandom};
        prev_dig = a_dig[47:0];
        a_start(v1);
        repeat (10) @(negedge clk);
        check_eq("mid_ready_low", a_ready, 1'b0);
        check_eq("mid_dig_stable", a_dig[47:0], prev_dig);
        a_vals  = ~v1;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        a_vals  = {$urandom, $urandom};
        lat = 11;
        wait_a(lat);
        check_eq("mid_latency", 64'(lat), 64'd49);
        verify_a("mid", v1);
        @(negedge clk);
        check_eq("mid_idle_after", a_ov, 1'b0);

        // Back-to-back with in_valid held high
        v1 = {$urandom, $urandom};
        v2 = {$urandom, $urandom};
        @(negedge clk);
        a_vals  = v1;
        a_valid = 1'b1;
        lat = 0;
        @(posedge clk);
        wait_a(lat);
        check_eq("b2b_first_latency", 64'(lat), 64'd49);
        check_eq("b2b_ready_in_done", a_ready, 1'b1);
        verify_a("b2b1", v1);
        a_vals = v2;
        @(negedge clk);
        check_eq("b2b_width", a_ov, 1'b0);
        check_eq("b2b_second_accepted", a_ready, 1'b0);
        a_valid = 1'b0;
        lat = 1;
        wait_a(lat);
        check_eq("b2b_pulse_spacing", 64'(lat), 64'd49);
        verify_a("b2b2", v2);
        @(negedge clk);
        check_eq("b2b_width2", a_ov, 1'b0);
        check_eq("b2b_idle_ready", a_ready, 1'b1);

        // Reset 20 cycles into a conversion
        a_start({$urandom, $urandom});
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", a_ov, 1'b0);
        check_eq("abort_dig", a_dig, 72'd0);
        check_eq("abort_blank", a_blank, 18'd0);
        check_eq("abort_ovf", a_ovf, 6'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (a_ov) pulses++;
        end
        check_eq("abort_no_pulse", 64'(pulses), 64'd0);
        check_eq("abort_ready", a_ready, 1'b1);
        check_eq("abort_dig_held", a_dig, 72'd0);
        a_run("post_abort", {8'd255, 8'd1, 8'd10, 8'd200, 8'd99, 8'd100});

        // DIGITS=2 saturation
        b_run("b_sat", {8'd99, 8'd255});
        check_eq("b_sat_const_dig", b_dig, 16'h9999);
        check_eq("b_sat_const_ovf", b_ovf, 2'b01);
        b_run("b_edge", {8'd9, 8'd100});
        b_run("b_zero", {8'd10, 8'd0});
        for (int i = 0; i < 3; i++)
            b_run($sformatf("b_rnd%0d", i), 16'($urandom));

        // Wide single channel
        c_run("c_9999", 16'd9999);
        check_eq("c_9999_const", c_dig, 16'h9999);
        c_run("c_10000", 16'd10000);
        check_eq("c_10000_ovf_const", c_ovf, 1'b1);
        c_run("c_max", 16'd65535);
        c_run("c_zero", 16'd0);
        c_run("c_1234", 16'd1234);
        for (int i = 0; i < 3; i++)
            c_run($sformatf("c_rnd%0d", i), 16'($urandom_range(0, 65535)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_decimalizer.md
SEQ_DECIMALIZER -- requirements
Module: seq_decimalizer

Interface
REQ-001 SHALL provide parameter W_IN, default 8, the bit width of each unsigned binary input value (legal range 1..16).
REQ-002 SHALL provide parameter DIGITS, default 3, the number of BCD digits produced per channel (legal range 1..4).
REQ-003 SHALL provide parameter CHANNELS, default 6, the number of values converted per transaction (legal range 1..8).
REQ-004 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL provide port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-006 SHALL provide port in_valid, input, 1, request to start a conversion of in_values.
REQ-007 SHALL provide port in_ready, output, 1, high when a new request is accepted.
REQ-008 SHALL provide port in_values, input, CHANNELS*W_IN, the packed inputs; channel c occupies bits [c*W_IN +: W_IN].
REQ-009 SHALL provide port out_valid, output, 1, a one-cycle pulse marking completed results.
REQ-010 SHALL provide port out_digits, output, CHANNELS*DIGITS*4, the packed BCD results; digit d of channel c occupies bits [(c*DIGITS+d)*4 +: 4], with d=0 the least significant.
REQ-011 SHALL provide port out_blank, output, CHANNELS*DIGITS, the per-digit leading-zero mask, using the same index order as out_digits.
REQ-012 SHALL provide port out_overflow, output, CHANNELS, the per-channel saturation flag.

Function
REQ-013 SHALL implement states IDLE, CONVERT and DONE.
REQ-014 SHALL drive in_ready high in IDLE and DONE, and low in CONVERT.
REQ-015 SHALL, on a clock edge with in_valid and in_ready both high, capture all of in_values, reset the channel and bit counters to 0, and enter CONVERT.
REQ-016 SHALL, in CONVERT, process exactly one input bit per cycle using shift-add-3 (double-dabble), MSB first, one channel at a time in order 0..CHANNELS-1.
REQ-017 SHALL give each channel a working register of DIGITS*4+W_IN bits, cleared before that channel's first bit is processed.
REQ-018 SHALL, after W_IN bit cycles on a channel, write that channel's result and advance to the next channel; the conversion occupies exactly CHANNELS*W_IN cycles in CONVERT.
REQ-019 SHALL enter DONE after the last bit of channel CHANNELS-1, and assert out_valid for exactly that one DONE cycle; with defaults, out_valid rises 49 cycles after the accepting edge.
REQ-020 SHALL, when a captured value exceeds 10^DIGITS-1, set out_overflow[c]=1 and force all DIGITS digits of that channel to 9, discarding the truncated double-dabble result.
REQ-021 SHALL otherwise set out_overflow[c]=0 and output the exact decimal value of the channel.
REQ-022 SHALL set out_blank for digit d>0 of channel c to 1 when digit d and every more-significant digit of that channel are 0; digit 0 is never blank.
REQ-023 SHALL hold out_digits, out_blank and out_overflow stable from the DONE cycle until the next DONE cycle, and never change them during CONVERT.
REQ-024 SHALL, when in DONE with in_valid high, accept the new request on the same edge and go directly to CONVERT (back-to-back operation with no idle cycle).
REQ-025 SHALL, when in DONE with in_valid low, return to IDLE.
REQ-026 SHALL ignore in_valid and any changes to in_values during CONVERT.
REQ-027 SHALL size its counters from CHANNELS and W_IN so that no count wraps inside a transaction.

Reset
REQ-028 SHALL, while rst_n is low, immediately force state IDLE, out_valid=0, out_digits=0, out_blank=0, out_overflow=0, and clear all counters and working registers.
REQ-029 SHALL drive in_ready=1 from the cycle after rst_n deasserts.
REQ-030 SHALL, if reset is asserted during CONVERT, abort the conversion, produce no out_valid for it, and leave outputs at their reset values.

Verification
REQ-031 SHALL cover: defaults, in_values channels {0,7,42,99,255,100} -> out_valid at cycle +49; digits {000,007,042,099,255,100}; out_overflow=0; blank masks (d2,d1) = {11,11,10,10,00,00}.
REQ-032 SHALL cover: DIGITS=2, channel value 255 -> digits 99, out_overflow=1; value 99 -> digits 99, out_overflow=0.
REQ-033 SHALL cover: two requests with in_valid held high -> the second is accepted in the DONE cycle; out_valid pulses exactly 49 cycles apart, each pulse one cycle wide.
REQ-034 SHALL cover: rst_n low at cycle 20 of CONVERT -> no out_valid, all outputs 0, in_ready=1 after release, and a subsequent conversion is correct.
REQ-035 SHALL cover: in_values changed and in_valid pulsed during CONVERT -> results reflect the originally captured values only.
REQ-036 SHALL cover: W_IN=16, DIGITS=4, CHANNELS=1, value 9999 -> 9999 with out_overflow=0; value 10000 -> 9999 with out_overflow=1; latency 17 cycles.
